request_agent_bank: RTL and testbench
=====================================

// Module: request_agent_bank
// PURPOSE
//  Requester side of the round-robin arbiter/priority_register pair: N agents that
//  queue jobs, raise reqs, take encoded grants and occupy the resource for a fixed
//  burst. Drives the arbiter's reqs_i and consumes its grants_o/any_grant_o.
//  Flags grants that break the protocol.
// PARAMETERS
//  N_REQ      8   number of requesters; must equal the arbiter width
//  BURST_LEN  3   cycles an agent holds the resource per grant; must be >= 1
//  PEND_W     4   pending-job counter width; each agent saturates at 2**PEND_W-1
// PORTS
//  clock        in   1             rising-edge clock
//  reset        in   1             asynchronous, active-low reset
//  job_i        in   N_REQ         1-cycle pulse per bit: add one job to that agent
//  grant_idx_i  in   $clog2(N_REQ) encoded grant (arbiter grants_o)
//  grant_vld_i  in   1             grant_idx_i is valid (arbiter any_grant_o)
//  reqs_o       out  N_REQ         registered request vector to the arbiter
//  busy_o       out  N_REQ         agent is in SERVE
//  done_o       out  N_REQ         1-cycle pulse on the agent's last SERVE cycle
//  overflow_o   out  1             sticky: a job was dropped because its counter was full
//  proto_err_o  out  1             sticky: grant to an agent whose reqs_o bit was low
// BEHAVIOUR
//  - Reset: every agent goes to IDLE with pending=0. reqs_o, busy_o, done_o,
//    overflow_o and proto_err_o all read 0. Asserting reset mid-burst aborts the
//    burst with no done_o pulse.
//  - Per-agent FSM. All outputs are registered (reqs_o=(st==REQ), busy_o=(st==SERVE)):
//    IDLE : pending>0 -> REQ next cycle. Otherwise stay in IDLE.
//    REQ  : grant_vld_i && grant_idx_i==k -> SERVE, pending-=1, burst cnt=0.
//           Otherwise stay in REQ. The req is held until granted and is never withdrawn.
//    SERVE: cnt increments each cycle. When cnt==BURST_LEN-1, done_o[k]=1 that cycle.
//           The next state is REQ if pending>0 (after this cycle's update), else IDLE.
//  - Grant sampling: the grant is combinational from reqs_o and sampled at the posedge.
//    reqs_o[k] falls on the cycle after the grant edge.
//    Minimum re-request gap is BURST_LEN cycles.
//  - Pending counter: job_i[k] adds 1 and a grant subtracts 1.
//    Both in the same cycle: no change.
//    Job while pending==max and no grant: job dropped, overflow_o set.
//    Never wraps.
//  - Grants in IDLE or SERVE: proto_err_o set; state and pending unchanged.
//    grant_vld_i=0: grant_idx_i ignored.
//  - Sticky flags clear only on reset.
//  - Agents are independent. Several agents may sit in SERVE at once; exclusivity is
//    the arbiter's job and is not checked here.
// STRUCTURE
//  - arb_pkg: N_REQ_DEF, IDX_W=$clog2(N_REQ), agent_state_e {IDLE,REQ,SERVE} (2-bit).
//  - Sub-module request_agent: one FSM + pending counter + burst counter, with per-agent
//    job/grant_hit inputs and req/busy/done/ovf/err outputs.
//  - Top: generate loop over N_REQ; decodes grant_idx_i into a one-hot grant_hit;
//    ORs ovf/err into the sticky registers.
// TESTING (bench: this block + arbiter + priority_register in closed loop, BURST_LEN=3)
//  1. Reset low 2 cycles, then high, no jobs -> reqs_o=0, busy_o=0, done_o=0, flags 0.
//  2. job_i=8'h01 one pulse -> reqs_o=8'h01 next cycle; granted; busy_o[0] for exactly
//     3 cycles; done_o[0] on the 3rd; then IDLE.
//  3. job_i=8'hFF one pulse -> grants rotate 0,1,...,7 with no agent granted twice.
//     Every done_o bit pulses exactly once; reqs_o ends at 8'h00.
//  4. 16 back-to-back job_i[2] pulses with no grants (agent 2 held in reset of
//     arbiter path / forced grant_vld_i=0) -> pending saturates at 15, overflow_o=1 on
//     16th; then 15 bursts complete.
//  5. Force grant_vld_i=1, idx=5 while reqs_o[5]=0 -> proto_err_o=1, stays 1;
//     agent 5 stays IDLE.
//  6. Pull reset low mid-SERVE on agent 3 -> all outputs 0 immediately with no
//     done_o[3]; after release, the agent is idle with pending=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the requester bank sitting in front of the round-robin arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_REQ_DEF = 8;
    localparam int IDX_W     = $clog2(N_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } agent_state_e;

endpackage

// File: rtl/request_agent.sv
// One requester: pending-job counter, IDLE/REQ/SERVE FSM and burst counter.
// Latency: job to req one cycle, grant to busy one cycle; req/busy/done registered, ovf/err are same-cycle pulses.
// Backpressure: req held until granted; jobs beyond the saturated counter are dropped and flagged on ovf.
module request_agent
    import arb_pkg::*;
#(
    parameter int BURST_LEN = 3,
    parameter int PEND_W    = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic job,
    input  logic grant_hit,
    output logic req,
    output logic busy,
    output logic done,
    output logic ovf,
    output logic err
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);

    agent_state_e      st, st_nxt;
    logic [PEND_W-1:0] pend, pend_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              take;

    always_comb begin
        take     = (st == REQ) && grant_hit;
        err      = grant_hit && (st != REQ);
        ovf      = 1'b0;
        pend_nxt = pend;
        st_nxt   = st;
        cnt_nxt  = cnt;

        // A job and a grant in the same cycle cancel; only a lone job can overflow.
        if (job && !take) begin
            if (pend == PEND_MAX) begin
                ovf = 1'b1;
            end else begin
                pend_nxt = pend + 1'b1;
            end
        end else if (!job && take) begin
            pend_nxt = pend - 1'b1;
        end

        case (st)
            IDLE: begin
                if (pend_nxt != '0) begin
                    st_nxt = REQ;
                end
            end
            REQ: begin
                if (take) begin
                    st_nxt  = SERVE;
                    cnt_nxt = '0;
                end
            end
            SERVE: begin
                if (cnt == CNT_LAST) begin
                    st_nxt = (pend_nxt != '0) ? REQ : IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Outputs are computed from next-state so they line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st   <= IDLE;
            pend <= '0;
            cnt  <= '0;
            req  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            st   <= st_nxt;
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
            req  <= (st_nxt == REQ);
            busy <= (st_nxt == SERVE);
            done <= (st_nxt == SERVE) && (cnt_nxt == CNT_LAST);
        end
    end

endmodule

// File: rtl/request_agent_bank.sv
// Bank of N_REQ requesters driving the arbiter's reqs and consuming its encoded grant.
// Latency: job to reqs_o one cycle; grant to busy_o one cycle; sticky flags one cycle after the event.
// Backpressure: each agent holds its req until granted; overflow_o/proto_err_o are sticky until reset.
module request_agent_bank
    import arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int BURST_LEN = 3,
    parameter int PEND_W    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         job_i,
    input  logic [$clog2(N_REQ)-1:0] grant_idx_i,
    input  logic                     grant_vld_i,
    output logic [N_REQ-1:0]         reqs_o,
    output logic [N_REQ-1:0]         busy_o,
    output logic [N_REQ-1:0]         done_o,
    output logic                     overflow_o,
    output logic                     proto_err_o
);

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] grant_hit;
    logic [N_REQ-1:0] ovf_vec;
    logic [N_REQ-1:0] err_vec;

    for (genvar k = 0; k < N_REQ; k++) begin : g_agent
        assign grant_hit[k] = grant_vld_i && (grant_idx_i == IW'(k));

        request_agent #(
            .BURST_LEN (BURST_LEN),
            .PEND_W    (PEND_W)
        ) u_agent (
            .clock     (clock),
            .reset     (reset),
            .job       (job_i[k]),
            .grant_hit (grant_hit[k]),
            .req       (reqs_o[k]),
            .busy      (busy_o[k]),
            .done      (done_o[k]),
            .ovf       (ovf_vec[k]),
            .err       (err_vec[k])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_o  <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            overflow_o  <= overflow_o  | (|ovf_vec);
            proto_err_o <= proto_err_o | (|err_vec);
        end
    end

endmodule

// File: tb/tb_request_agent_bank.sv
// Closed-loop bench: request_agent_bank against a small round-robin arbiter model, BURST_LEN=3.
// Latency/backpressure: n/a (bench).
// Directed vectors, all expectations hand-derived.
module tb_request_agent_bank;

    logic       clock;
    logic       rst_n;
    logic [7:0] job;
    logic [2:0] grant_idx;
    logic       grant_vld;
    logic [7:0] reqs_o, busy_o, done_o;
    logic       overflow_o, proto_err_o;

    logic       arb_en, force_en, force_vld;
    logic [2:0] force_idx;
    logic [2:0] ptr;
    logic       arb_vld;
    logic [2:0] arb_idx;

    int         n_checks;
    int         n_fail;
    int         done_cnt [8];
    int         grant_log[$];

    request_agent_bank #(.N_REQ(8), .BURST_LEN(3), .PEND_W(4)) dut (
        .clock       (clock),
        .reset       (rst_n),
        .job_i       (job),
        .grant_idx_i (grant_idx),
        .grant_vld_i (grant_vld),
        .reqs_o      (reqs_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .proto_err_o (proto_err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Round-robin arbiter: first set req at or after ptr.
    always_comb begin
        logic [2:0] j;
        arb_vld = 1'b0;
        arb_idx = '0;
        j       = '0;
        for (int i = 7; i >= 0; i--) begin
            j = ptr + 3'(i);
            if (reqs_o[j]) begin
                arb_vld = 1'b1;
                arb_idx = j;
            end
        end
    end

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (arb_en && arb_vld) ptr <= arb_idx + 3'd1;
    end

    assign grant_vld = force_en ? force_vld : (arb_en && arb_vld);
    assign grant_idx = force_en ? force_idx : arb_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 8; k++) done_cnt[k] = 0;
        grant_log.delete();
    endtask

    // Inputs are driven just after a posedge; the grant is logged once settled, outputs sampled 1ns after the edge.
    task automatic step();
        #1;
        if (grant_vld && !force_en) grant_log.push_back(int'(grant_idx));
        @(posedge clock);
        #1;
        for (int k = 0; k < 8; k++) done_cnt[k] += int'(done_o[k]);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        job       = '0;
        arb_en    = 1'b0;
        force_en  = 1'b0;
        force_vld = 1'b0;
        force_idx = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        clear_stats();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_stats();

        // 1: reset state
        do_reset();
        check("rst_reqs", reqs_o, 8'h00);
        check("rst_busy", busy_o, 8'h00);
        check("rst_done", done_o, 8'h00);
        check("rst_ovf",  overflow_o, 1'b0);
        check("rst_err",  proto_err_o, 1'b0);

        // 2: single job on agent 0
        arb_en = 1'b1;
        job    = 8'h01;
        step();
        job = 8'h00;
        check("t2_req",   reqs_o, 8'h01);
        check("t2_busy0", busy_o, 8'h00);
        step();
        check("t2_busy1", busy_o, 8'h01);
        check("t2_done1", done_o, 8'h00);
        check("t2_req1",  reqs_o, 8'h00);
        step();
        check("t2_busy2", busy_o, 8'h01);
        check("t2_done2", done_o, 8'h00);
        step();
        check("t2_busy3", busy_o, 8'h01);
        check("t2_done3", done_o, 8'h01);
        step();
        check("t2_busy4", busy_o, 8'h00);
        check("t2_done4", done_o, 8'h00);
        check("t2_reqs4", reqs_o, 8'h00);

        // 3: all agents once, rotation 0..7
        do_reset();
        arb_en = 1'b1;
        job    = 8'hFF;
        step();
        job = 8'h00;
        check("t3_reqs", reqs_o, 8'hFF);
        for (int c = 0; c < 16; c++) step();
        check("t3_ngrants", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check($sformatf("t3_order%0d", i), grant_log[i], i);
        for (int k = 0; k < 8; k++)
            check($sformatf("t3_done%0d", k), done_cnt[k], 1);
        check("t3_reqs_end", reqs_o, 8'h00);
        check("t3_busy_end", busy_o, 8'h00);
        check("t3_ovf",      overflow_o, 1'b0);
        check("t3_err",      proto_err_o, 1'b0);

        // 4: saturate agent 2 with no grants, then drain
        do_reset();
        for (int p = 1; p <= 16; p++) begin
            job = 8'h04;
            step();
            if (p == 15) check("t4_ovf15", overflow_o, 1'b0);
        end
        job = 8'h00;
        check("t4_ovf16", overflow_o, 1'b1);
        check("t4_req",   reqs_o, 8'h04);
        arb_en = 1'b1;
        for (int c = 0; c < 70; c++) step();
        check("t4_bursts",   done_cnt[2], 15);
        check("t4_reqs_end", reqs_o, 8'h00);
        check("t4_busy_end", busy_o, 8'h00);
        check("t4_ovf_hold", overflow_o, 1'b1);

        // 5: invalid grants
        do_reset();
        force_en  = 1'b1;
        force_vld = 1'b0;
        force_idx = 3'd5;
        step();
        check("t5_vld0_err", proto_err_o, 1'b0);
        force_vld = 1'b1;
        step();
        force_vld = 1'b0;
        force_en  = 1'b0;
        check("t5_err", proto_err_o, 1'b1);
        step();
        step();
        check("t5_err_sticky", proto_err_o, 1'b1);
        check("t5_reqs",       reqs_o, 8'h00);
        check("t5_busy",       busy_o, 8'h00);

        // 6: reset in the middle of agent 3's burst
        do_reset();
        arb_en = 1'b1;
        job    = 8'h08;
        step();
        job = 8'h00;
        check("t6_req", reqs_o, 8'h08);
        step();
        check("t6_busy", busy_o, 8'h08);
        step();
        check("t6_mid_done", done_o, 8'h00);
        rst_n = 1'b0;
        #1;
        check("t6_rst_reqs", reqs_o, 8'h00);
        check("t6_rst_busy", busy_o, 8'h00);
        check("t6_rst_done", done_o, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check("t6_no_done", done_cnt[3], 0);
        check("t6_reqs",    reqs_o, 8'h00);
        check("t6_busy",    busy_o, 8'h00);
        check("t6_err",     proto_err_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
